// File: rtl/seven_segment_scanner.sv
// Time-multiplexed N-digit seven-segment scanner with one shared hex decoder,
// a blanking guard between digits and frame-aligned commit of buffered values.
module seven_segment_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000,
  parameter int BLANK_GAP   = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [NUM_DIGITS-1:0]   digit_enable,
  input  logic                    lz_suppress,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_done
);

  localparam int MAXPH = (REFRESH_DIV > BLANK_GAP) ? REFRESH_DIV : BLANK_GAP;
  localparam int CW    = $clog2(MAXPH + 1);
  localparam int IW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;
  localparam logic [0:0] ST_INIT  = (BLANK_GAP > 0) ? ST_BLANK : ST_SHOW;

  localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_GAP > 0) ? BLANK_GAP - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  logic [0:0]              state, state_nx;
  logic [IW-1:0]           idx, idx_nx;
  logic [CW-1:0]           cnt, cnt_nx;
  logic [4*NUM_DIGITS-1:0] active, active_nx, pending;
  logic                    pending_valid, pending_valid_nx;
  logic                    frame_end, accept;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic                    zero_run, lit;
  logic [3:0]              nib;
  logic [6:0]              seg_nx;
  logic [NUM_DIGITS-1:0]   sel_nx;
  logic                    fd_nx;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_to_seg = 7'b1111110;
      4'h1: hex_to_seg = 7'b0110000;
      4'h2: hex_to_seg = 7'b1101101;
      4'h3: hex_to_seg = 7'b1111001;
      4'h4: hex_to_seg = 7'b0110011;
      4'h5: hex_to_seg = 7'b1011011;
      4'h6: hex_to_seg = 7'b1011111;
      4'h7: hex_to_seg = 7'b1110000;
      4'h8: hex_to_seg = 7'b1111111;
      4'h9: hex_to_seg = 7'b1111011;
      4'hA: hex_to_seg = 7'b1110111;
      4'hB: hex_to_seg = 7'b0011111;
      4'hC: hex_to_seg = 7'b1001110;
      4'hD: hex_to_seg = 7'b0111101;
      4'hE: hex_to_seg = 7'b1001111;
      default: hex_to_seg = 7'b1000111;
    endcase
  endfunction

  assign frame_end = (state == ST_SHOW) && (idx == IDX_LAST) && (cnt == SHOW_LAST);
  assign accept    = load_valid && load_ready;

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    cnt_nx   = cnt + 1'b1;
    if (state == ST_BLANK) begin
      if (cnt == BLANK_LAST) begin
        state_nx = ST_SHOW;
        cnt_nx   = '0;
      end
    end else if (cnt == SHOW_LAST) begin
      state_nx = ST_INIT;
      cnt_nx   = '0;
      idx_nx   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
  end

  always_comb begin
    active_nx        = (frame_end && pending_valid) ? pending : active;
    pending_valid_nx = pending_valid;
    if (accept)
      pending_valid_nx = 1'b1;
    else if (frame_end)
      pending_valid_nx = 1'b0;
  end

  // Digit i is suppressible when every nibble from the top down to i is zero.
  always_comb begin
    zero_run = 1'b1;
    lz_blank = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      zero_run = zero_run && (active_nx[4*(NUM_DIGITS-1-k) +: 4] == 4'h0);
      if (k != NUM_DIGITS - 1)
        lz_blank[NUM_DIGITS-1-k] = zero_run;
    end
  end

  // Outputs are decoded from next-cycle state so the registered outputs line
  // up with the state they describe, while enables/lz act one cycle later.
  always_comb begin
    nib    = active_nx[idx_nx*4 +: 4];
    lit    = (state_nx == ST_SHOW) && digit_enable[idx_nx] &&
             !(lz_suppress && lz_blank[idx_nx]);
    seg_nx = lit ? hex_to_seg(nib) : '0;
    sel_nx = lit ? (NUM_DIGITS'(1) << idx_nx) : '0;
    fd_nx  = (state_nx == ST_SHOW) && (idx_nx == IDX_LAST) && (cnt_nx == SHOW_LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_INIT;
      idx           <= '0;
      cnt           <= '0;
      active        <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      load_ready    <= 1'b1;
      seg_out       <= '0;
      digit_sel     <= '0;
      frame_done    <= 1'b0;
    end else begin
      state         <= state_nx;
      idx           <= idx_nx;
      cnt           <= cnt_nx;
      active        <= active_nx;
      if (accept)
        pending     <= value_in;
      pending_valid <= pending_valid_nx;
      load_ready    <= !pending_valid_nx;
      seg_out       <= seg_nx;
      digit_sel     <= sel_nx;
      frame_done    <= fd_nx;
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Randomized self-checking bench for seven_segment_scanner against a
// cycle-position reference model of the scan, load buffer and suppression rules.
module tb_seven_segment_scanner;

  localparam int N     = 4;
  localparam int R     = 4;
  localparam int G     = 1;
  localparam int SLOT  = R + G;
  localparam int FRAME = N * SLOT;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [15:0]   value_in = '0;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic [3:0]    digit_enable = 4'hF;
  logic          lz_suppress = 1'b0;
  logic [6:0]    seg_out;
  logic [3:0]    digit_sel;
  logic          frame_done;

  int checks = 0;
  int failures = 0;

  int          cyc = 1;
  logic [15:0] m_active = '0;
  logic [15:0] m_pending = '0;
  bit          m_pv = 1'b0;

  logic [6:0] lut [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                           7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                           7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                           7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
  logic [6:0] exp_12af [4] = '{7'b1000111, 7'b1110111, 7'b1101101, 7'b0110000};

  always #5 clk = ~clk;

  seven_segment_scanner #(
    .NUM_DIGITS (N),
    .REFRESH_DIV(R),
    .BLANK_GAP  (G)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .value_in    (value_in),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .digit_enable(digit_enable),
    .lz_suppress (lz_suppress),
    .seg_out     (seg_out),
    .digit_sel   (digit_sel),
    .frame_done  (frame_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic compare_outputs();
    int pos, d, off;
    bit show, sup, lit;
    logic [3:0] nib;
    logic [3:0] e_sel;
    logic [6:0] e_seg;
    pos   = (cyc - 1) % FRAME;
    d     = pos / SLOT;
    off   = pos % SLOT;
    show  = off >= G;
    nib   = 4'(m_active >> (4 * d));
    sup   = lz_suppress && (d != 0) && ((m_active >> (4 * d)) == 16'h0);
    lit   = show && digit_enable[d] && !sup;
    e_sel = lit ? 4'(1 << d) : 4'b0;
    e_seg = lit ? lut[nib] : 7'b0;
    check("digit_sel", 32'(digit_sel), 32'(e_sel));
    check("seg_out", 32'(seg_out), 32'(e_seg));
    check("frame_done", 32'(frame_done), 32'(pos == FRAME - 1));
    check("load_ready", 32'(load_ready), 32'(!m_pv));
  endtask

  task automatic tick();
    bit accept, boundary;
    accept   = load_valid && !m_pv;
    boundary = ((cyc - 1) % FRAME) == FRAME - 1;
    @(posedge clk);
    if (boundary && m_pv) begin
      m_active = m_pending;
      m_pv     = 1'b0;
    end
    if (accept) begin
      m_pending = value_in;
      m_pv      = 1'b1;
    end
    cyc++;
    #1;
    compare_outputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset      = 1'b0;
    load_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset    = 1'b1;
    cyc      = 1;
    m_active = '0;
    m_pv     = 1'b0;
    #1;
    compare_outputs();
  endtask

  task automatic load(input logic [15:0] v);
    int budget;
    budget = 3 * FRAME;
    while (m_pv && budget > 0) begin
      tick();
      budget--;
    end
    check("ready_timeout", 32'(m_pv), 32'(0));
    value_in   = v;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic align(input int pos_target);
    int budget;
    budget = FRAME;
    while (((cyc - 1) % FRAME) != pos_target && budget > 0) begin
      tick();
      budget--;
    end
    check("align_timeout", 32'((cyc - 1) % FRAME), 32'(pos_target));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();
    tick();
    check("rst_d0_sel", 32'(digit_sel), 32'(4'b0001));
    check("rst_d0_seg", 32'(seg_out), 32'(7'b1111110));
    repeat (FRAME + 2) tick();

    // 12AF decode, all enabled
    digit_enable = 4'hF;
    lz_suppress  = 1'b0;
    load(16'h12AF);
    repeat (2 * FRAME) tick();
    align(G);
    for (int d = 0; d < N; d++) begin
      check("dig12af", 32'(seg_out), 32'(exp_12af[d]));
      repeat (SLOT) tick();
    end

    // back-to-back loads while buffer full
    load(16'h1111);
    value_in   = 16'h2222;
    load_valid = 1'b1;
    repeat (3 * FRAME) tick();
    load_valid = 1'b0;
    repeat (FRAME) tick();

    // leading-zero suppression
    lz_suppress = 1'b1;
    load(16'h0050);
    repeat (2 * FRAME) tick();
    align(G + SLOT);
    check("lz_d1_seg", 32'(seg_out), 32'(7'b1011011));
    repeat (2 * SLOT) tick();
    check("lz_d3_sel", 32'(digit_sel), 32'(4'b0000));
    load(16'h0000);
    repeat (2 * FRAME) tick();
    lz_suppress = 1'b0;

    // partial enables
    digit_enable = 4'b0101;
    repeat (2 * FRAME) tick();
    digit_enable = 4'hF;

    // random traffic
    for (int i = 0; i < 600; i++) begin
      value_in     = 16'($urandom);
      load_valid   = ($urandom_range(0, 3) == 0);
      digit_enable = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
      lz_suppress  = 1'($urandom);
      tick();
    end
    load_valid   = 1'b0;
    digit_enable = 4'hF;
    lz_suppress  = 1'b0;

    // asynchronous reset during SHOW with a pending load
    repeat (2 * FRAME) tick();
    load(16'h8888);
    align(FRAME - 1);
    tick();
    load(16'h9999);
    tick();
    check("pend_before_rst", 32'(m_pv), 32'(1));
    check("lit_before_rst", 32'(digit_sel), 32'(4'b0001));
    #2;
    reset = 1'b0;
    #1;
    check("arst_sel", 32'(digit_sel), 32'(0));
    check("arst_seg", 32'(seg_out), 32'(0));
    check("arst_fd", 32'(frame_done), 32'(0));
    check("arst_ready", 32'(load_ready), 32'(1));
    do_reset();
    repeat (2 * FRAME) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
